// File: rtl/debug_sched_pkg.sv
// Shared types and constants for the debug display scheduler.
package debug_sched_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  // Upper two bits of the source tag digit, giving C/D/E/F on the display.
  localparam logic [1:0] SRC_TAG = 2'b11;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_AUTO   = 2'd1,
    S_FROZEN = 2'd2
  } sched_state_e;

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
    return sel + SEL_W'(1);
  endfunction

endpackage

// File: rtl/debug_debounce.sv
// Two-flop synchroniser followed by a stable-sample debounce counter.
module debug_debounce #(
  parameter int   DEBOUNCE_CYCLES = 600000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample that agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/debug_display_sched.sv
// Source scheduler for the hex-LED debug display: manual, auto-rotate or frozen.
// Optional macro DEBUG_SCHED_TAG_EN puts {2'b11, src_sel} into digit 7.
//
//   state    | meaning
//   S_MANUAL | debounced key presses advance the source
//   S_AUTO   | source advances every ROTATE_CYCLES or on a press
//   S_FROZEN | display word, selection and rotate counter held
module debug_display_sched
  import debug_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 600000,
  parameter int ROTATE_CYCLES   = 30000000
) (
  input  logic        CLK_I,
  input  logic        reset_n,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  input  logic        key_next_n,
  input  logic        sw_auto,
  input  logic        sw_freeze,
  output logic [31:0] display_o,
  output logic [1:0]  src_sel_o,
  output logic        update_o,
  output logic        frozen_o
);

  localparam int               ROT_W    = $clog2(ROTATE_CYCLES);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_CYCLES - 1);

  logic key_lvl, auto_lvl, freeze_lvl;
  logic key_prev_q;
  logic press;

  sched_state_e     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [ROT_W-1:0] rot_q, rot_d;
  logic [31:0]      disp_q, disp_d;
  logic             upd_q, upd_d;
  logic             advance;
  logic [31:0]      src_arr [NUM_SRC];
  logic [31:0]      live_word;

  debug_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_db_key (
    .clk_i   (CLK_I),
    .rst_n_i (reset_n),
    .raw_i   (key_next_n),
    .level_o (key_lvl)
  );

  debug_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_db_auto (
    .clk_i   (CLK_I),
    .rst_n_i (reset_n),
    .raw_i   (sw_auto),
    .level_o (auto_lvl)
  );

  debug_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_db_freeze (
    .clk_i   (CLK_I),
    .rst_n_i (reset_n),
    .raw_i   (sw_freeze),
    .level_o (freeze_lvl)
  );

  assign press = key_prev_q & ~key_lvl;

  assign src_arr[0] = src0;
  assign src_arr[1] = src1;
  assign src_arr[2] = src2;
  assign src_arr[3] = src3;

  always_comb begin
    live_word = src_arr[sel_q];
`ifdef DEBUG_SCHED_TAG_EN
    live_word[31:28] = {SRC_TAG, sel_q};
`endif
  end

  always_ff @(posedge CLK_I or negedge reset_n) begin
    if (!reset_n) begin
      key_prev_q <= 1'b1;
      state_q    <= S_MANUAL;
      sel_q      <= '0;
      rot_q      <= '0;
      disp_q     <= '0;
      upd_q      <= 1'b0;
    end else begin
      key_prev_q <= key_lvl;
      state_q    <= state_d;
      sel_q      <= sel_d;
      rot_q      <= rot_d;
      disp_q     <= disp_d;
      upd_q      <= upd_d;
    end
  end

  // Freeze wins over auto, auto over manual; checked every cycle.
  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    advance = 1'b0;
    unique case (state_q)
      S_MANUAL: begin
        if (freeze_lvl) begin
          state_d = S_FROZEN;
        end else if (auto_lvl) begin
          state_d = S_AUTO;
          rot_d   = '0;
        end else if (press) begin
          advance = 1'b1;
        end
      end
      S_AUTO: begin
        if (freeze_lvl) begin
          state_d = S_FROZEN;
        end else if (!auto_lvl) begin
          state_d = S_MANUAL;
        end else if (press || (rot_q == ROT_LAST)) begin
          advance = 1'b1;
          rot_d   = '0;
        end else begin
          rot_d = rot_q + ROT_W'(1);
        end
      end
      S_FROZEN: begin
        if (!freeze_lvl) begin
          if (auto_lvl) begin
            state_d = S_AUTO;
            rot_d   = '0;
          end else begin
            state_d = S_MANUAL;
          end
        end
      end
      default: state_d = S_MANUAL;
    endcase

    sel_d = advance ? next_sel(sel_q) : sel_q;
    upd_d = advance;
    // The word captured on the edge that enters S_FROZEN is the snapshot.
    disp_d = (state_q == S_FROZEN) ? disp_q : live_word;
  end

  assign display_o = disp_q;
  assign src_sel_o = sel_q;
  assign update_o  = upd_q;
  assign frozen_o  = (state_q == S_FROZEN);

endmodule

// File: tb/tb_debug_display_sched.sv
// Directed bench for debug_display_sched with short debounce and rotate periods.
module tb_debug_display_sched;

  logic        CLK_I;
  logic        reset_n;
  logic [31:0] src0, src1, src2, src3;
  logic        key_next_n;
  logic        sw_auto;
  logic        sw_freeze;
  logic [31:0] display_o;
  logic [1:0]  src_sel_o;
  logic        update_o;
  logic        frozen_o;

  int total;
  int bad;

  debug_display_sched #(.DEBOUNCE_CYCLES(4), .ROTATE_CYCLES(16)) dut (
    .CLK_I      (CLK_I),
    .reset_n    (reset_n),
    .src0       (src0),
    .src1       (src1),
    .src2       (src2),
    .src3       (src3),
    .key_next_n (key_next_n),
    .sw_auto    (sw_auto),
    .sw_freeze  (sw_freeze),
    .display_o  (display_o),
    .src_sel_o  (src_sel_o),
    .update_o   (update_o),
    .frozen_o   (frozen_o)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  function automatic logic [31:0] ed(input logic [1:0] sel, input logic [31:0] val);
    logic [31:0] w;
    w = val;
`ifdef DEBUG_SCHED_TAG_EN
    w[31:28] = {2'b11, sel};
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raw key low for 8 samples: advance lands 7 edges after the fall.
  task automatic press_expect(input logic [1:0] prev_sel, input logic [1:0] new_sel,
                              input logic [31:0] new_src);
    key_next_n = 1'b0;
    repeat (6) tick();
    check("press_pre_sel", 32'(src_sel_o), 32'(prev_sel));
    tick();
    check("press_sel", 32'(src_sel_o), 32'(new_sel));
    check("press_update", 32'(update_o), 32'd1);
    tick();
    check("press_update_clr", 32'(update_o), 32'd0);
    check("press_display", display_o, ed(new_sel, new_src));
    key_next_n = 1'b1;
    repeat (8) tick();
    check("release_sel", 32'(src_sel_o), 32'(new_sel));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    key_next_n = 1'b1;
    sw_auto    = 1'b0;
    sw_freeze  = 1'b0;
    src0 = 32'h11111111;
    src1 = 32'h22222222;
    src2 = 32'h33333333;
    src3 = 32'h44444444;

    repeat (3) tick();
    check("rst_display", display_o, 32'h0);
    check("rst_sel", 32'(src_sel_o), 32'd0);
    check("rst_update", 32'(update_o), 32'd0);
    check("rst_frozen", 32'(frozen_o), 32'd0);

    reset_n = 1'b1;
    tick();
    check("first_display", display_o, ed(2'd0, 32'h11111111));

    // 2-cycle glitch on the key is rejected
    key_next_n = 1'b0;
    repeat (2) tick();
    key_next_n = 1'b1;
    repeat (8) tick();
    check("glitch_sel", 32'(src_sel_o), 32'd0);
    check("glitch_update", 32'(update_o), 32'd0);

    // valid presses, wrap 3 -> 0, live src1 change
    press_expect(2'd0, 2'd1, 32'h22222222);
    press_expect(2'd1, 2'd2, 32'h33333333);
    press_expect(2'd2, 2'd3, 32'h44444444);
    press_expect(2'd3, 2'd0, 32'h11111111);
    press_expect(2'd0, 2'd1, 32'h22222222);
    src1 = 32'h55555555;
    tick();
    check("live_src1", display_o, ed(2'd1, 32'h55555555));
    press_expect(2'd1, 2'd2, 32'h33333333);
    press_expect(2'd2, 2'd3, 32'h44444444);

    // auto-rotate: enters S_AUTO 7 edges after switch, advances 16 later
    sw_auto = 1'b1;
    repeat (22) tick();
    check("auto_pre_sel", 32'(src_sel_o), 32'd3);
    tick();
    check("auto_wrap_sel", 32'(src_sel_o), 32'd0);
    check("auto_wrap_upd", 32'(update_o), 32'd1);
    repeat (15) tick();
    check("auto_dwell_sel", 32'(src_sel_o), 32'd0);
    tick();
    check("auto_sel1", 32'(src_sel_o), 32'd1);
    check("auto_upd1", 32'(update_o), 32'd1);

    // press timed to land on the expiry cycle
    repeat (9) tick();
    key_next_n = 1'b0;
    repeat (6) tick();
    check("coinc_pre_sel", 32'(src_sel_o), 32'd1);
    tick();
    check("coinc_sel", 32'(src_sel_o), 32'd2);
    check("coinc_upd", 32'(update_o), 32'd1);
    tick();
    check("coinc_single_sel", 32'(src_sel_o), 32'd2);
    check("coinc_single_upd", 32'(update_o), 32'd0);
    key_next_n = 1'b1;
    repeat (14) tick();
    check("coinc_restart_pre", 32'(src_sel_o), 32'd2);
    tick();
    check("coinc_restart_sel", 32'(src_sel_o), 32'd3);

    // back to manual, step to src2
    sw_auto = 1'b0;
    repeat (10) tick();
    check("manual_sel", 32'(src_sel_o), 32'd3);
    check("manual_upd", 32'(update_o), 32'd0);
    press_expect(2'd3, 2'd0, 32'h11111111);
    press_expect(2'd0, 2'd1, 32'h55555555);
    press_expect(2'd1, 2'd2, 32'h33333333);

    // freeze on src2
    sw_freeze = 1'b1;
    repeat (6) tick();
    check("freeze_pre", 32'(frozen_o), 32'd0);
    tick();
    check("freeze_on", 32'(frozen_o), 32'd1);
    check("freeze_disp", display_o, ed(2'd2, 32'h33333333));
    src2 = 32'hDEADBEEF;
    tick();
    check("freeze_hold", display_o, ed(2'd2, 32'h33333333));
    key_next_n = 1'b0;
    repeat (8) tick();
    key_next_n = 1'b1;
    repeat (8) tick();
    check("freeze_press_sel", 32'(src_sel_o), 32'd2);
    check("freeze_press_upd", 32'(update_o), 32'd0);
    check("freeze_press_disp", display_o, ed(2'd2, 32'h33333333));

    sw_freeze = 1'b0;
    repeat (6) tick();
    check("unfreeze_pre", 32'(frozen_o), 32'd1);
    tick();
    check("unfreeze_off", 32'(frozen_o), 32'd0);
    check("unfreeze_hold", display_o, ed(2'd2, 32'h33333333));
    tick();
    check("unfreeze_disp", display_o, ed(2'd2, 32'hDEADBEEF));
    check("unfreeze_sel", 32'(src_sel_o), 32'd2);

    // reset in the middle of a rotation
    src1    = 32'h22222222;
    sw_auto = 1'b1;
    repeat (12) tick();
    reset_n = 1'b0;
    #1;
    check("async_rst_disp", display_o, 32'h0);
    check("async_rst_sel", 32'(src_sel_o), 32'd0);
    check("async_rst_upd", 32'(update_o), 32'd0);
    check("async_rst_frozen", 32'(frozen_o), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_disp", display_o, ed(2'd0, 32'h11111111));
    repeat (21) tick();
    check("post_rst_pre_sel", 32'(src_sel_o), 32'd0);
    tick();
    check("post_rst_sel", 32'(src_sel_o), 32'd1);
    check("post_rst_upd", 32'(update_o), 32'd1);
    tick();
    check("post_rst_disp1", display_o, ed(2'd1, 32'h22222222));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
